// File: rtl/dds_sweep_pkg.sv
// Shared types and default widths for the DDS frequency-sweep controller.
package dds_sweep_pkg;

    localparam int unsigned FW_W_DEF    = 32;
    localparam int unsigned DWELL_W_DEF = 24;
    localparam int unsigned IDX_W_DEF   = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

endpackage

// File: rtl/sweep_step_calc.sv
// Combinational next-frequency-word calculation, clamped to f_stop in either
// direction, plus detection of the final sweep point.
module sweep_step_calc #(
    parameter int unsigned FW_W = 32
) (
    input  logic [FW_W-1:0] fword,
    input  logic [FW_W-1:0] f_step,
    input  logic [FW_W-1:0] f_stop,
    input  logic            dir,
    output logic [FW_W-1:0] next,
    output logic            is_last
);

    logic [FW_W:0] sum;
    logic [FW_W:0] diff;

    assign sum  = {1'b0, fword} + {1'b0, f_step};
    assign diff = {1'b0, fword} - {1'b0, f_step};

    // dir=1 means a downward sweep; the MSB of diff is the borrow.
    always_comb begin
        next    = f_stop;
        is_last = 1'b1;
        if (dir) begin
            if (!diff[FW_W] && (diff[FW_W-1:0] >= f_stop)) begin
                next = diff[FW_W-1:0];
            end
            is_last = (f_step == '0) || (fword <= f_stop);
        end else begin
            if (!sum[FW_W] && (sum[FW_W-1:0] <= f_stop)) begin
                next = sum[FW_W-1:0];
            end
            is_last = (f_step == '0) || (fword >= f_stop);
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep controller: steps the frequency word from f_start to f_stop
// with a per-point dwell. Define SWEEP_DOWN_EN to allow downward sweeps.
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int unsigned FW_W    = FW_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [FW_W-1:0]    f_start,
    input  logic [FW_W-1:0]    f_stop,
    input  logic [FW_W-1:0]    f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FW_W-1:0]    fword,
    output logic               fword_vld,
    output logic [IDX_W-1:0]   point_idx,
    output logic               busy,
    output logic               done
);

    state_t             state_q;
    logic [FW_W-1:0]    start_q;
    logic [FW_W-1:0]    stop_q;
    logic [FW_W-1:0]    step_q;
    logic [DWELL_W-1:0] reload_q;
    logic               cont_q;
    logic               dir_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [FW_W-1:0]    fword_q;
    logic               fword_vld_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic               done_q;

    logic [DWELL_W-1:0] reload_d;
    logic               dir_d;
    logic [FW_W-1:0]    next_fword;
    logic               is_last;

    // A dwell of 0 behaves like 1, so the counter reload saturates at 0.
    assign reload_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

`ifdef SWEEP_DOWN_EN
    assign dir_d = (f_start > f_stop);
`else
    assign dir_d = 1'b0;
`endif

    sweep_step_calc #(
        .FW_W(FW_W)
    ) u_step (
        .fword  (fword_q),
        .f_step (step_q),
        .f_stop (stop_q),
        .dir    (dir_q),
        .next   (next_fword),
        .is_last(is_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            reload_q    <= '0;
            cont_q      <= 1'b0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            fword_q     <= '0;
            fword_vld_q <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fword_vld_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        start_q     <= f_start;
                        stop_q      <= f_stop;
                        step_q      <= f_step;
                        reload_q    <= reload_d;
                        cont_q      <= cont;
                        dir_q       <= dir_d;
                        cnt_q       <= reload_d;
                        fword_q     <= f_start;
                        fword_vld_q <= 1'b1;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= DWELL;
                    end
                end
                DWELL: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end else if (!is_last) begin
                        fword_q     <= next_fword;
                        idx_q       <= idx_q + IDX_W'(1);
                        fword_vld_q <= 1'b1;
                        cnt_q       <= reload_q;
                    end else if (cont_q) begin
                        fword_q     <= start_q;
                        idx_q       <= '0;
                        fword_vld_q <= 1'b1;
                        cnt_q       <= reload_q;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fword     = fword_q;
    assign fword_vld = fword_vld_q;
    assign point_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep controller that sits directly upstream of the DDS phase accumulator and drives its 32-bit frequency control word. It steps the word from a start value to a stop value in fixed increments, holds each point for a programmable dwell time, and flags every new point so the downstream measurement path can sample synchronously. It supports single-shot or continuous sweeps, with abort at any time.

## Interface
- FW_W, 32, frequency-word width (matches DDS accumulator)
- DWELL_W, 24, dwell-counter width
- IDX_W, 16, point-index width
- clk  in  1  system clock, shared with the DDS
- rst  in  1  synchronous, active-high reset
- start  in  1  sweep request pulse, sampled only in IDLE
- stop  in  1  abort pulse, honoured in any state
- cont  in  1  0 = single sweep, 1 = continuous; latched at start
- f_start  in  FW_W  first frequency word; latched at start
- f_stop  in  FW_W  last frequency word; latched at start
- f_step  in  FW_W  increment per point; latched at start
- dwell  in  DWELL_W  clocks per point, 0 treated as 1; latched at start
- fword  out  FW_W  frequency control word to the DDS
- fword_vld  out  1  one-cycle pulse when fword takes a new value
- point_idx  out  IDX_W  index of the current point, 0 at f_start
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse when a single sweep completes

## Operation
- FSM states: IDLE, DWELL.
- IDLE, start=1, stop=0 → DWELL. Latch config into shadow registers. fword←f_start, point_idx←0, fword_vld←1, busy←1, dwell counter←max(dwell,1)−1.
- DWELL, counter≠0 → decrement.
- DWELL, counter=0, current point not last → fword←next, point_idx+1 (wraps at 2^IDX_W), fword_vld pulse, counter reloads.
- DWELL, counter=0, current point last:
  - cont=0 → IDLE, done pulse, busy←0, fword holds.
  - cont=1 → fword←f_start, point_idx←0, fword_vld pulse.
- Next point: next = fword + f_step, computed at FW_W+1 bits. If there is a carry, or next > f_stop, next←f_stop.
- Last point: fword = f_stop.
- f_step=0: f_start is the only point; it counts as last.
- f_start ≥ f_stop: single point at f_start. Without the macro, this includes f_start > f_stop.
- stop in any state → IDLE next edge. busy←0, no done pulse, fword holds its value. If start and stop arrive together, stop wins.
- start while busy is ignored. Shadow registers isolate the sweep from input changes mid-sweep.
- Reset: fword=0, fword_vld=0, point_idx=0, busy=0, done=0, state IDLE. Reset takes priority over every other input.

## Timing
- All outputs are registered. fword changes on the edge that samples start, so latency is 1 cycle.
- Each point is held exactly max(dwell,1) cycles. There is no gap between points.
- A single sweep of N points ends N·max(dwell,1) cycles after the start edge. On that edge done=1 and busy=0.
- fword_vld is coincident with the first cycle of each new fword value.

## Configuration
- SWEEP_DOWN_EN defined: when latched f_start > f_stop, the sweep runs downward.
  - next = fword − f_step.
  - Clamp to f_stop on borrow or when next < f_stop.
  - Last point is still fword = f_stop.
- SWEEP_DOWN_EN undefined: direction is always up, and f_start > f_stop gives a single point at f_start.

## Structure
- Package dds_sweep_pkg holds:
  - the state enum (IDLE, DWELL);
  - the FW_W, DWELL_W and IDX_W defaults.
- Sub-module sweep_step_calc: a combinational clamped add/subtract. Inputs are fword, f_step, f_stop and dir. Outputs are next and is_last.

## Test plan
- Basic sweep: f_start=100, f_stop=130, f_step=10, dwell=3, cont=0.
  - fword = 100,110,120,130, 3 cycles each.
  - 4 fword_vld pulses, point_idx 0..3.
  - done 12 cycles after the start edge.
- Clamp: 100→125, step 10, dwell=1.
  - fword = 100,110,120,125, then done.
- Overflow: f_start=0xFFFFFF00, f_stop=0xFFFFFFFF, f_step=0x80.
  - fword = 0xFFFFFF00, 0xFFFFFF80, 0xFFFFFFFF.
  - No wrap to low values.
- Continuous plus abort: 0→20, step 10, dwell=2, cont=1.
  - fword sequence 0,10,20,0,10…
  - stop mid-point → busy=0 next edge, fword holds, no done.
  - Repeat with start and stop in the same cycle: stays IDLE.
- Edge cases:
  - dwell=0 → 1 cycle per point.
  - f_step=0 → single point, done after 1 dwell.
  - start while busy → ignored.
  - rst mid-sweep → all outputs return to reset values.
- SWEEP_DOWN_EN build: f_start=130, f_stop=100, step 10.
  - Defined: fword = 130,120,110,100.
  - Undefined: single point 130, then done.
